// File: rtl/wb_trace_if.sv
// Writeback trace and golden-stream bundle between the CPU/testbench side
// (master) and the commit checker (slave).
interface wb_trace_if;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;

  modport master (
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output gold_valid, gold_pc, gold_wnum, gold_wdata,
    input  gold_ready
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  gold_valid, gold_pc, gold_wnum, gold_wdata,
    output gold_ready
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Commit monitor: buffers golden trace entries in a small FIFO and compares
// every register-file commit from the writeback trace against the FIFO head.
// Never back-pressures the core; reports sticky flags, a first-failure
// snapshot and commit/mismatch counters.
module wb_trace_checker #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  wb_trace_if.slave     bus,
  output logic          err,
  output logic          underflow,
  output logic [31:0]   err_pc,
  output logic [31:0]   err_got,
  output logic [31:0]   err_exp,
  output logic [31:0]   commit_cnt,
  output logic [15:0]   mismatch_cnt,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  // Golden entry storage
  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        commit;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        fail;
  logic [31:0] mask;
  logic [31:0] head_pc;
  logic [4:0]  head_wnum;
  logic [31:0] head_wdata;
  logic [31:0] got_masked;
  logic [31:0] exp_masked;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign bus.gold_ready = (fifo_count != FULL_COUNT);

  assign head_pc    = mem_pc[rd_ptr];
  assign head_wnum  = mem_wnum[rd_ptr];
  assign head_wdata = mem_wdata[rd_ptr];

  // Decode commit, push/pop and pass/fail for the current cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    mask       = '0;
    commit     = (bus.debug_wb_rf_we != 4'd0) && (bus.debug_wb_rf_wnum != 5'd0);
    fifo_empty = (fifo_count == '0);
    push       = bus.gold_valid && bus.gold_ready;
    pop        = commit && !fifo_empty;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{bus.debug_wb_rf_we[i]}};
    end
    got_masked = bus.debug_wb_rf_wdata & mask;
    // An empty FIFO never bypasses a same-cycle push into the compare.
    exp_masked = fifo_empty ? 32'd0 : (head_wdata & mask);
    fail       = 1'b0;
    if (commit) begin
      if (fifo_empty) begin
        fail = 1'b1;
      end else if ((bus.debug_wb_pc != head_pc) ||
                   (bus.debug_wb_rf_wnum != head_wnum) ||
                   (got_masked != exp_masked)) begin
        fail = 1'b1;
      end
    end
  end

  // Write accepted golden entries at the tail.
  // NOTE: the entry storage has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= bus.gold_pc;
      mem_wnum[wr_ptr]  <= bus.gold_wnum;
      mem_wdata[wr_ptr] <= bus.gold_wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky flags, counters and first-failure snapshot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err          <= 1'b0;
      underflow    <= 1'b0;
      err_pc       <= '0;
      err_got      <= '0;
      err_exp      <= '0;
      commit_cnt   <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (commit) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
      if (commit && fifo_empty) begin
        underflow <= 1'b1;
      end
      if (fail) begin
        err <= 1'b1;
        if (mismatch_cnt != 16'hFFFF) begin
          mismatch_cnt <= mismatch_cnt + 16'd1;
        end
        if (!err) begin
          err_pc  <= bus.debug_wb_pc;
          err_got <= got_masked;
          err_exp <= exp_masked;
        end
      end
    end
  end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Synthesizable commit monitor downstream of the CPU top; consumes its debug_wb_* writeback trace.
- Buffers golden trace entries from a valid/ready stream in a small FIFO and compares each register-file commit against the FIFO head.
- Reports sticky error and underflow flags, the first-mismatch snapshot, and commit/mismatch counters for the SoC status registers.

Parameters:
- DEPTH, 8, golden FIFO entries; power of 2, minimum 2.
- AW, 3, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous active-low reset.
- debug_wb_pc  in  32  PC of the instruction in WB.
- debug_wb_rf_we  in  4  RF byte write enables.
- debug_wb_rf_wnum  in  5  destination register number.
- debug_wb_rf_wdata  in  32  writeback data.
- gold_valid  in  1  golden entry valid.
- gold_ready  out  1  FIFO can accept an entry.
- gold_pc  in  32  expected PC.
- gold_wnum  in  5  expected register number.
- gold_wdata  in  32  expected data.
- err  out  1  sticky: any mismatch or underflow seen.
- underflow  out  1  sticky: commit arrived with the FIFO empty.
- err_pc  out  32  debug_wb_pc of the first failing commit.
- err_got  out  32  masked debug_wb_rf_wdata of the first failing commit.
- err_exp  out  32  masked gold_wdata of the first failing commit; 0 on underflow.
- commit_cnt  out  32  number of commits checked; wraps.
- mismatch_cnt  out  16  number of failing commits; saturates at 16'hFFFF.
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset, taken on a clk edge with resetn=0: every output register and the FIFO pointers clear to 0.
  - err, underflow, err_* and both counters read 0; fifo_count reads 0.
  - gold_ready goes high in the cycle after reset deasserts.
  - Reset mid-run discards FIFO contents and clears the latched snapshot.
- Push: gold_valid && gold_ready at a rising edge writes the entry at the tail.
  - gold_ready = (fifo_count != DEPTH), combinational from registered state.
  - gold_ready is independent of a same-cycle pop, so a slot freed by a pop is visible only the next cycle.
- Commit event: (debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0). A write to r0 or zero enables is ignored entirely: no pop, no count.
- On a commit with the FIFO non-empty:
  - Pop the head.
  - Build mask m with each byte m[8i+7:8i] = {8{debug_wb_rf_we[i]}}.
  - Fail if pc differs, or wnum differs, or (wdata & m) != (gold_wdata & m).
- On a commit with the FIFO empty:
  - Fail and set underflow; nothing is popped.
  - A same-cycle push does not bypass into that compare; the pushed entry is stored normally.
- Simultaneous push and pop with the FIFO non-empty: occupancy unchanged, and both take effect.
- Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- Every commit increments commit_cnt, pass or fail.
- On every fail, mismatch_cnt increments (saturating) and err sets.
- Snapshot: err_pc/err_got/err_exp load only on the first fail after reset, when err was 0. Later fails leave the snapshot unchanged.
- Latency: all flags, counters and the snapshot update at the rising edge that samples the commit, so they are visible the next cycle.
- No stall path back to the core: the checker never blocks writeback.

Test Plan:
- Push 3 entries (pc 0x1c000000/04/08, wnum 1/2/3, data 0x11/0x22/0x33), then 3 matching commits with we=4'hF -> commit_cnt=3, err=0, fifo_count=0.
- Push pc 0x1c000000, wnum 4, data 0xAABBCCDD; commit the same with we=4'b0011 and data 0x0000CCDD -> pass, err=0.
- Push data 0x5; commit data 0x6 at pc 0x1c000010 -> next cycle err=1, mismatch_cnt=1, err_pc=0x1c000010, err_got=0x6, err_exp=0x5. A second bad commit leaves err_pc unchanged and sets mismatch_cnt=2.
- Commit with the FIFO empty -> underflow=1, err=1, err_exp=0, fifo_count stays 0. A commit with wnum=0 or we=0 -> commit_cnt unchanged.
- Fill to DEPTH=8 -> gold_ready=0. Commit and hold gold_valid in the same cycle -> no push that cycle; gold_ready=1 next cycle, then the push lands and fifo_count=8.
- Mid-run, with fifo_count=5 and err=1, drive resetn=0 for 1 cycle -> all outputs 0 and fifo_count=0 next cycle.
